// File: rtl/mult_rom.sv
// 4x4 product lookup ROM (unsigned; signed two's complement when MULT_ROM_SIGNED_EN is defined).
// Latency: 1 cycle, one lookup per cycle, outputs straight from flops.
// Backpressure: none; every in_valid is accepted and out_valid pulses the next cycle.
module mult_rom (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] n1,
    input  logic [3:0] n2,
    output logic [7:0] result,
    output logic       out_valid
);

    // Row index is n1 (address bits [7:4]), column index is n2 (bits [3:0]).
`ifdef MULT_ROM_SIGNED_EN
    // Nibble codes 8..15 represent -8..-1, so each row runs 0..7 then -8..-1.
    localparam logic [7:0] PROD [0:255] = '{
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, -8'sd8, -8'sd7, -8'sd6, -8'sd5, -8'sd4, -8'sd3, -8'sd2, -8'sd1,
        8'sd0, 8'sd2, 8'sd4, 8'sd6, 8'sd8, 8'sd10, 8'sd12, 8'sd14, -8'sd16, -8'sd14, -8'sd12, -8'sd10, -8'sd8, -8'sd6, -8'sd4, -8'sd2,
        8'sd0, 8'sd3, 8'sd6, 8'sd9, 8'sd12, 8'sd15, 8'sd18, 8'sd21, -8'sd24, -8'sd21, -8'sd18, -8'sd15, -8'sd12, -8'sd9, -8'sd6, -8'sd3,
        8'sd0, 8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20, 8'sd24, 8'sd28, -8'sd32, -8'sd28, -8'sd24, -8'sd20, -8'sd16, -8'sd12, -8'sd8, -8'sd4,
        8'sd0, 8'sd5, 8'sd10, 8'sd15, 8'sd20, 8'sd25, 8'sd30, 8'sd35, -8'sd40, -8'sd35, -8'sd30, -8'sd25, -8'sd20, -8'sd15, -8'sd10, -8'sd5,
        8'sd0, 8'sd6, 8'sd12, 8'sd18, 8'sd24, 8'sd30, 8'sd36, 8'sd42, -8'sd48, -8'sd42, -8'sd36, -8'sd30, -8'sd24, -8'sd18, -8'sd12, -8'sd6,
        8'sd0, 8'sd7, 8'sd14, 8'sd21, 8'sd28, 8'sd35, 8'sd42, 8'sd49, -8'sd56, -8'sd49, -8'sd42, -8'sd35, -8'sd28, -8'sd21, -8'sd14, -8'sd7,
        8'sd0, -8'sd8, -8'sd16, -8'sd24, -8'sd32, -8'sd40, -8'sd48, -8'sd56, 8'sd64, 8'sd56, 8'sd48, 8'sd40, 8'sd32, 8'sd24, 8'sd16, 8'sd8,
        8'sd0, -8'sd7, -8'sd14, -8'sd21, -8'sd28, -8'sd35, -8'sd42, -8'sd49, 8'sd56, 8'sd49, 8'sd42, 8'sd35, 8'sd28, 8'sd21, 8'sd14, 8'sd7,
        8'sd0, -8'sd6, -8'sd12, -8'sd18, -8'sd24, -8'sd30, -8'sd36, -8'sd42, 8'sd48, 8'sd42, 8'sd36, 8'sd30, 8'sd24, 8'sd18, 8'sd12, 8'sd6,
        8'sd0, -8'sd5, -8'sd10, -8'sd15, -8'sd20, -8'sd25, -8'sd30, -8'sd35, 8'sd40, 8'sd35, 8'sd30, 8'sd25, 8'sd20, 8'sd15, 8'sd10, 8'sd5,
        8'sd0, -8'sd4, -8'sd8, -8'sd12, -8'sd16, -8'sd20, -8'sd24, -8'sd28, 8'sd32, 8'sd28, 8'sd24, 8'sd20, 8'sd16, 8'sd12, 8'sd8, 8'sd4,
        8'sd0, -8'sd3, -8'sd6, -8'sd9, -8'sd12, -8'sd15, -8'sd18, -8'sd21, 8'sd24, 8'sd21, 8'sd18, 8'sd15, 8'sd12, 8'sd9, 8'sd6, 8'sd3,
        8'sd0, -8'sd2, -8'sd4, -8'sd6, -8'sd8, -8'sd10, -8'sd12, -8'sd14, 8'sd16, 8'sd14, 8'sd12, 8'sd10, 8'sd8, 8'sd6, 8'sd4, 8'sd2,
        8'sd0, -8'sd1, -8'sd2, -8'sd3, -8'sd4, -8'sd5, -8'sd6, -8'sd7, 8'sd8, 8'sd7, 8'sd6, 8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1
    };
`else
    localparam logic [7:0] PROD [0:255] = '{
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15,
        8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18, 8'd20, 8'd22, 8'd24, 8'd26, 8'd28, 8'd30,
        8'd0, 8'd3, 8'd6, 8'd9, 8'd12, 8'd15, 8'd18, 8'd21, 8'd24, 8'd27, 8'd30, 8'd33, 8'd36, 8'd39, 8'd42, 8'd45,
        8'd0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd28, 8'd32, 8'd36, 8'd40, 8'd44, 8'd48, 8'd52, 8'd56, 8'd60,
        8'd0, 8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd35, 8'd40, 8'd45, 8'd50, 8'd55, 8'd60, 8'd65, 8'd70, 8'd75,
        8'd0, 8'd6, 8'd12, 8'd18, 8'd24, 8'd30, 8'd36, 8'd42, 8'd48, 8'd54, 8'd60, 8'd66, 8'd72, 8'd78, 8'd84, 8'd90,
        8'd0, 8'd7, 8'd14, 8'd21, 8'd28, 8'd35, 8'd42, 8'd49, 8'd56, 8'd63, 8'd70, 8'd77, 8'd84, 8'd91, 8'd98, 8'd105,
        8'd0, 8'd8, 8'd16, 8'd24, 8'd32, 8'd40, 8'd48, 8'd56, 8'd64, 8'd72, 8'd80, 8'd88, 8'd96, 8'd104, 8'd112, 8'd120,
        8'd0, 8'd9, 8'd18, 8'd27, 8'd36, 8'd45, 8'd54, 8'd63, 8'd72, 8'd81, 8'd90, 8'd99, 8'd108, 8'd117, 8'd126, 8'd135,
        8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150,
        8'd0, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99, 8'd110, 8'd121, 8'd132, 8'd143, 8'd154, 8'd165,
        8'd0, 8'd12, 8'd24, 8'd36, 8'd48, 8'd60, 8'd72, 8'd84, 8'd96, 8'd108, 8'd120, 8'd132, 8'd144, 8'd156, 8'd168, 8'd180,
        8'd0, 8'd13, 8'd26, 8'd39, 8'd52, 8'd65, 8'd78, 8'd91, 8'd104, 8'd117, 8'd130, 8'd143, 8'd156, 8'd169, 8'd182, 8'd195,
        8'd0, 8'd14, 8'd28, 8'd42, 8'd56, 8'd70, 8'd84, 8'd98, 8'd112, 8'd126, 8'd140, 8'd154, 8'd168, 8'd182, 8'd196, 8'd210,
        8'd0, 8'd15, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90, 8'd105, 8'd120, 8'd135, 8'd150, 8'd165, 8'd180, 8'd195, 8'd210, 8'd225
    };
`endif

    logic [7:0] addr;
    assign addr = {n1, n2};

    // result only moves on an accepted lookup so it holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= PROD[addr];
            end
        end
    end

endmodule

// File: tb/tb_mult_rom.sv
module tb_mult_rom;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [7:0] result;
    logic       out_valid;

    int vectors;
    int errors;

    mult_rom dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .n1        (n1),
        .n2        (n2),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int p;
`ifdef MULT_ROM_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return p[7:0];
    endfunction

    // Drive operands away from the edge, then return 1 ns after the sampling edge.
    task automatic lookup(input logic v, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = v;
        n1       = a;
        n2       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] exp;
        rst_n = 1'b0; in_valid = 1'b0; n1 = 4'h0; n2 = 4'h0;
        #3;
        vectors++;
        if (result !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: result=%h out_valid=%b required 00/0", result, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lookup(1'b1, 4'hF, 4'hF);
        exp = ref_prod(4'hF, 4'hF);
        vectors++;
        if (result !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: result=%h out_valid=%b required %h/1", result, out_valid, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (result !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: result=%h out_valid=%b required 00/0", result, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] exp;
        exp = ref_prod(4'd3, 4'd5);
        lookup(1'b1, 4'd3, 4'd5);
        vectors++;
        if (result !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single: result=%h out_valid=%b required %h/1", result, out_valid, exp);
        end
        lookup(1'b0, 4'hA, 4'hB);
        vectors++;
        if (result !== exp || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: result=%h out_valid=%b required %h/0", result, out_valid, exp);
        end
        // Operand wiggles between edges must not disturb the held result.
        #2; n1 = 4'h7; n2 = 4'h9; #1;
        vectors++;
        if (result !== exp || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_midcycle: result=%h out_valid=%b required %h/0", result, out_valid, exp);
        end
    endtask

    task automatic test_boundaries;
        logic [3:0] a [6] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h8, 4'h8};
        logic [3:0] b [6] = '{4'h9, 4'h1, 4'hF, 4'h7, 4'h8, 4'h7};
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp = ref_prod(a[i], b[i]);
            lookup(1'b1, a[i], b[i]);
            vectors++;
            if (result !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL boundary_%0h_%0h: result=%h out_valid=%b required %h/1", a[i], b[i], result, out_valid, exp);
            end
        end
`ifndef MULT_ROM_SIGNED_EN
        vectors++;
        if (ref_prod(4'hF, 4'hF) !== 8'hE1 || result !== ref_prod(4'h8, 4'h7)) begin
            errors++;
            $display("FAIL boundary_model: model(F,F)=%h required e1", ref_prod(4'hF, 4'hF));
        end
`endif
    endtask

    task automatic test_sweep;
        logic [7:0] addr;
        logic [7:0] exp;
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i);
            exp  = ref_prod(addr[7:4], addr[3:0]);
            lookup(1'b1, addr[7:4], addr[3:0]);
            vectors++;
            if (result !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d: result=%h out_valid=%b required %h/1", i, result, out_valid, exp);
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) begin
            lookup(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)));
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        vectors++;
        if (result !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstream_clear: result=%h out_valid=%b required 00/0", result, out_valid);
        end
        #2;
        rst_n = 1'b1;
        exp = ref_prod(4'd7, 4'd7);
        lookup(1'b1, 4'd7, 4'd7);
        vectors++;
        if (result !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstream_first: result=%h out_valid=%b required %h/1", result, out_valid, exp);
        end
    endtask

    task automatic test_random;
        logic [7:0] held;
        logic       v;
        logic [3:0] a, b;
        held = result;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(1));
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            if (v) held = ref_prod(a, b);
            lookup(v, a, b);
            vectors++;
            if (result !== held || out_valid !== v) begin
                errors++;
                $display("FAIL random_%0d: result=%h out_valid=%b required %h/%b", i, result, out_valid, held, v);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_boundaries();
        test_sweep();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
